// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC decimator.
// Contents:
//   clog2      - ceiling log2 of a positive integer (0 for 1)
//   cic_width  - full-precision internal width IW + N*clog2(R*D)
//   CIC_*      - legal ranges for stage count and decimation factor
package cic_pkg;

    localparam int CIC_N_MIN = 1;
    localparam int CIC_N_MAX = 6;
    localparam int CIC_R_MIN = 2;
    localparam int CIC_R_MAX = 1024;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

    function automatic int cic_width(input int iw, input int n, input int r, input int d);
        return iw + n * clog2(r * d);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section running at the decimated rate.
//   data_o = data_i - data_i[n-D], registered; the delay line and the
//   output register only move on valid_i, so gaps between decimated
//   samples never disturb the difference.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   valid_i     decimated sample present on data_i
//   data_i      W-bit sample from the previous stage
//   valid_o     data_o updated this cycle
//   data_o      W-bit difference, held between valid pulses
module cic_comb_stage #(
    parameter int W = 22,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] dly_q [D];
    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < D; j++) begin
                dly_q[j] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q   <= data_i - dly_q[D-1];
                dly_q[0] <= data_i;
                for (int unsigned j = 1; j < D; j++) begin
                    dly_q[j] <= dly_q[j-1];
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at input rate, decimate by R,
// N comb stages at the output rate, scaled to OW bits.
// Configuration macro: CIC_ROUND_EN
//   defined   - round half up before dropping LSBs (when W > OW), saturate
//               positive overflow; one extra register, latency N+3
//   undefined - truncate (floor); latency N+2
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data valid this cycle
//   in_data    IW-bit signed sample
//   out_valid  one-cycle pulse per decimated output
//   out_data   OW-bit signed output, held between pulses
module cic_decimator
    import cic_pkg::*;
#(
    parameter int N  = 3,
    parameter int R  = 4,
    parameter int D  = 1,
    parameter int IW = 16,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data
);

    localparam int W  = cic_width(IW, N, R, D);
    localparam int PW = clog2(R);
    localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

    if (N < CIC_N_MIN || N > CIC_N_MAX || R < CIC_R_MIN || R > CIC_R_MAX ||
        (D != 1 && D != 2)) begin : g_param_check
        $error("cic_decimator: illegal parameters N=%0d R=%0d D=%0d", N, R, D);
    end

    // Integrators: modular W-bit arithmetic, wrap is harmless for the combs.
    logic [W-1:0] integ_q [N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
        end else if (in_valid) begin
            integ_q[0] <= integ_q[0] + {{(W-IW){in_data[IW-1]}}, in_data};
            for (int unsigned k = 1; k < N; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Phase counter and decimation strobe
    logic [PW-1:0] phase_q, phase_d;
    logic          strobe_q, strobe_d;

    always_comb begin
        phase_d  = phase_q;
        strobe_d = 1'b0;
        if (in_valid) begin
            if (phase_q == PH_LAST) begin
                phase_d  = '0;
                strobe_d = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    // Decimated sample register feeds comb stage 0; it captures the last
    // integrator the cycle after the strobe, which fixes latency at N+2.
    logic [W-1:0] dec_q;
    logic         dec_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
        end else begin
            dec_vld_q <= strobe_q;
            if (strobe_q) begin
                dec_q <= integ_q[N-1];
            end
        end
    end

    // Comb chain
    logic [N:0][W-1:0] cd;
    logic [N:0]        cv;

    assign cd[0] = dec_q;
    assign cv[0] = dec_vld_q;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(.W(W), .D(D)) u_comb (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (cv[k]),
            .data_i  (cd[k]),
            .valid_o (cv[k+1]),
            .data_o  (cd[k+1])
        );
    end

    // Pre-scale value, one bit wider so the rounding add cannot wrap.
    logic [W:0] pre_d;
    logic [W:0] pre_s;
    logic       pre_v;

`ifdef CIC_ROUND_EN
    localparam int HSH = (W > OW) ? (W - OW - 1) : 0;
    localparam logic [W:0] HALF = (W > OW) ? ((W+1)'(1) << HSH) : '0;

    always_comb begin
        pre_d = {cd[N][W-1], cd[N]} + HALF;
    end

    logic [W:0] pre_q;
    logic       pre_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q     <= '0;
            pre_vld_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pre_vld_q <= cv[N];
        end
    end

    assign pre_s = pre_q;
    assign pre_v = pre_vld_q;
`else
    always_comb begin
        pre_d = {cd[N][W-1], cd[N]};
    end

    assign pre_s = pre_d;
    assign pre_v = cv[N];
`endif

    logic signed [OW-1:0] scaled;

    if (W > OW) begin : g_narrow
        logic [OW:0] top;
        logic        unused_lsbs;
        assign top         = pre_s[W -: OW+1];
        assign unused_lsbs = ^pre_s[W-OW-1:0];
        // top bits disagree only after a rounding carry into the sign: clamp to max
        assign scaled = (top[OW] != top[OW-1]) ? {1'b0, {(OW-1){1'b1}}} : top[OW-1:0];
    end else begin : g_wide
        logic signed [W-1:0] full;
        logic                unused_ext;
        assign full       = pre_s[W-1:0];
        assign unused_ext = pre_s[W];
        assign scaled     = OW'(full) <<< (OW - W);
    end

    // Output register
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] out_data_q,  out_data_d;

    always_comb begin
        out_valid_d = pre_v;
        out_data_d  = out_data_q;
        if (pre_v) begin
            out_data_d = scaled;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator (N=3 R=4 D=1 IW=16, W=22).
// Three instances share clock, reset and data; each has its own valid:
//   u_dc  OW=16  DC, negative DC, gapped input, mid-run reset
//   u_imp OW=22  impulse response (no scaling)
//   u_rnd OW=14  truncation / rounding of DC 1002
// The driver pushes {value, cycle} when it issues the R-th sample of a
// group; per-instance monitors pop and compare on out_valid.
module tb_cic_decimator;

    localparam int N  = 3;
    localparam int R  = 4;
    localparam int D  = 1;
    localparam int IW = 16;
`ifdef CIC_ROUND_EN
    localparam int LAT = N + 3;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = N + 2;
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 v0, v1, v2;
    logic signed [IW-1:0] din;
    logic                 ov0, ov1, ov2;
    logic signed [15:0]   od0;
    logic signed [21:0]   od1;
    logic signed [13:0]   od2;

    cic_decimator #(.N(N), .R(R), .D(D), .IW(IW), .OW(16)) u_dc (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(din),
        .out_valid(ov0), .out_data(od0));

    cic_decimator #(.N(N), .R(R), .D(D), .IW(IW), .OW(22)) u_imp (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(din),
        .out_valid(ov1), .out_data(od1));

    cic_decimator #(.N(N), .R(R), .D(D), .IW(IW), .OW(14)) u_rnd (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(din),
        .out_valid(ov2), .out_data(od2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int checks = 0;
    int errors = 0;
    int etab[4];
    int ph[3];
    int grp[3];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_tab(input int a, input int b, input int c, input int d);
        etab[0] = a; etab[1] = b; etab[2] = c; etab[3] = d;
    endtask

    task automatic push(input int s, input int val, input int c);
        exp_t e;
        e.val = val;
        e.cyc = c;
        case (s)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    // Issue one accepted sample to instance s; the accepting edge is the next posedge.
    task automatic send(input int s, input int x);
        @(negedge clk);
        v0  = (s == 0);
        v1  = (s == 1);
        v2  = (s == 2);
        din = x[IW-1:0];
        if (ph[s] == R - 1) begin
            push(s, etab[(grp[s] < 3) ? grp[s] : 3], cyc + 1 + LAT);
            grp[s]++;
            ph[s] = 0;
        end else begin
            ph[s]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        end
    endtask

    // One reset edge; pending expectations are dropped with the in-flight samples.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        sb0.delete(); sb1.delete(); sb2.delete();
        for (int i = 0; i < 3; i++) begin
            ph[i]  = 0;
            grp[i] = 0;
        end
        @(negedge clk);
        chk("rst_dc_valid", int'(ov0), 0);
        chk("rst_dc_data", int'(od0), 0);
        chk("rst_rnd_data", int'(od2), 0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 20; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
            idle(1);
        end
        chk("drain_dc", sb0.size(), 0);
        chk("drain_imp", sb1.size(), 0);
        chk("drain_rnd", sb2.size(), 0);
        sb0.delete(); sb1.delete(); sb2.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov0) begin
            if (sb0.size() == 0) chk("dc_unexpected_pulse", 1, 0);
            else begin
                e = sb0.pop_front();
                chk("dc_data", int'(od0), e.val);
                chk("dc_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov1) begin
            if (sb1.size() == 0) chk("imp_unexpected_pulse", 1, 0);
            else begin
                e = sb1.pop_front();
                chk("imp_data", int'(od1), e.val);
                chk("imp_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov2) begin
            if (sb2.size() == 0) chk("rnd_unexpected_pulse", 1, 0);
            else begin
                e = sb2.pop_front();
                chk("rnd_data", int'(od2), e.val);
                chk("rnd_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        din = '0;
        for (int i = 0; i < 3; i++) begin
            ph[i]  = 0;
            grp[i] = 0;
        end
        repeat (3) @(negedge clk);
        do_reset();

        // DC 1000: comb output 4000, 44000, 64000... ; >>6 floors to 62, 687, 1000
        set_tab(62, 687, 1000, 1000);
        for (int i = 0; i < 60; i++) send(0, 1000);
        drain();
        idle(5);
        chk("dc_hold", int'(od0), 1000);

        // Negative DC, long enough for the integrators to wrap many times
        do_reset();
        set_tab(-63, -688, -1000, -1000);
        for (int i = 0; i < 200; i++) send(0, -1000);
        drain();

        // Gapped DC: same values, timing follows the accepting edges
        do_reset();
        set_tab(62, 687, 1000, 1000);
        for (int i = 0; i < 40; i++) begin
            send(0, 1000);
            idle(2);
        end
        drain();

        // Reset after 5 samples: group 0 output is discarded
        do_reset();
        set_tab(62, 687, 1000, 1000);
        for (int i = 0; i < 5; i++) send(0, 1000);
        do_reset();
        idle(LAT + 4);
        for (int i = 0; i < 3; i++) send(0, 1000);
        idle(LAT + 4);
        for (int i = 0; i < 5; i++) send(0, 1000);
        drain();

        // Impulse at phase 0: decimated response h[1], h[5], h[9] of
        // h = 1,3,6,10,12,12,10,6,3,1, then zero
        do_reset();
        set_tab(3, 12, 1, 0);
        send(1, 1);
        for (int i = 0; i < 15; i++) send(1, 0);
        drain();

        // DC 1002 into OW=14: 4008, 44088, 64128 >>8
        do_reset();
        if (RND) set_tab(16, 172, 251, 251);
        else     set_tab(15, 172, 250, 250);
        for (int i = 0; i < 40; i++) send(2, 1002);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
